// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-line memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 256;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GNT0  = 3'd1,
    ST_GNT1  = 3'd2,
    ST_DONE0 = 3'd3,
    ST_DONE1 = 3'd4
  } state_e;

  function automatic logic is_gnt(input state_e s);
    return (s == ST_GNT0) || (s == ST_GNT1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Winner selection from the request bits and the previous winner.
  always_comb begin
    gnt_valid = req[0] | req[1];
    if (req[0] && req[1]) begin
      gnt_idx = ~last_grant;
    end else if (req[1]) begin
      gnt_idx = PORT1;
    end else begin
      gnt_idx = PORT0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one cache-line Data Memory port between the icache (port 0) and the
// dcache (port 1); one grant at a time, held until the memory acks.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              err_o,
  output logic              busy_o
);

  state_e              state_r;
  state_e              state_next_s;
  logic                last_grant_r;
  logic                gnt_valid_s;
  logic                gnt_idx_s;
  logic                req_write_r;
  logic [ADDR_W-1:0]   req_addr_r;
  logic [DATA_W-1:0]   req_data_r;
  logic [DATA_W-1:0]   p0_data_r;
  logic [DATA_W-1:0]   p1_data_r;
  logic [CNT_W-1:0]    wdog_cnt_r;
  logic                err_r;
  logic                mem_enable_r;
  logic                p0_ack_r;
  logic                p1_ack_r;
  logic                busy_r;
  logic                mem_enable_next_s;
  logic                p0_ack_next_s;
  logic                p1_ack_next_s;
  logic                busy_next_s;

  rr_arbiter2 u_rr (
    .req        ({p1_enable_i, p0_enable_i}),
    .last_grant (last_grant_r),
    .gnt_valid  (gnt_valid_s),
    .gnt_idx    (gnt_idx_s)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; acks outside a grant state fall through untouched.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_next_s = (gnt_idx_s == PORT1) ? ST_GNT1 : ST_GNT0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_GNT0: begin
        if (mem_ack_i) begin
          state_next_s = ST_DONE0;
        end else begin
          state_next_s = ST_GNT0;
        end
      end
      ST_GNT1: begin
        if (mem_ack_i) begin
          state_next_s = ST_DONE1;
        end else begin
          state_next_s = ST_GNT1;
        end
      end
      ST_DONE0: state_next_s = ST_IDLE;
      ST_DONE1: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the strobes come straight off flops.
  always_comb begin
    mem_enable_next_s = is_gnt(state_next_s);
    p0_ack_next_s     = (state_next_s == ST_DONE0);
    p1_ack_next_s     = (state_next_s == ST_DONE1);
    busy_next_s       = (state_next_s != ST_IDLE);
  end

  // Output strobe registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_enable_r <= 1'b0;
      p0_ack_r     <= 1'b0;
      p1_ack_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      mem_enable_r <= mem_enable_next_s;
      p0_ack_r     <= p0_ack_next_s;
      p1_ack_r     <= p1_ack_next_s;
      busy_r       <= busy_next_s;
    end
  end

  // Capture the winner's request at grant time; later input changes are ignored.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant_r <= PORT1;
      req_write_r  <= 1'b0;
      req_addr_r   <= {ADDR_W{1'b0}};
      req_data_r   <= {DATA_W{1'b0}};
    end else if ((state_r == ST_IDLE) && gnt_valid_s) begin
      last_grant_r <= gnt_idx_s;
      if (gnt_idx_s == PORT1) begin
        req_write_r <= p1_write_i;
        req_addr_r  <= p1_addr_i;
        req_data_r  <= p1_data_i;
      end else begin
        req_write_r <= p0_write_i;
        req_addr_r  <= p0_addr_i;
        req_data_r  <= p0_data_i;
      end
    end
  end

  // Read-return registers; writes leave the previous line in place.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      p0_data_r <= {DATA_W{1'b0}};
      p1_data_r <= {DATA_W{1'b0}};
    end else begin
      if ((state_r == ST_GNT0) && mem_ack_i && !req_write_r) begin
        p0_data_r <= mem_data_i;
      end
      if ((state_r == ST_GNT1) && mem_ack_i && !req_write_r) begin
        p1_data_r <= mem_data_i;
      end
    end
  end

  // Watchdog: cleared in IDLE (every grant is entered from IDLE), saturating in a grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wdog_cnt_r <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if (state_r == ST_IDLE) begin
        wdog_cnt_r <= {CNT_W{1'b0}};
      end else if (is_gnt(state_r) && (wdog_cnt_r != CNT_W'(TIMEOUT))) begin
        wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
      end
      // The edge that takes the count to TIMEOUT is the one that flags the error.
      if (is_gnt(state_r) && !mem_ack_i && (wdog_cnt_r == CNT_W'(TIMEOUT - 1))) begin
        err_r <= 1'b1;
      end
    end
  end

  assign mem_enable_o = mem_enable_r;
  assign mem_write_o  = req_write_r;
  assign mem_addr_o   = req_addr_r;
  assign mem_data_o   = req_data_r;
  assign p0_ack_o     = p0_ack_r;
  assign p1_ack_o     = p1_ack_r;
  assign p0_data_o    = p0_data_r;
  assign p1_data_o    = p1_data_r;
  assign err_o        = err_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected acks and
// memory transactions; a memory model and an ack monitor pop and compare.
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 256;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic              port;
    logic              chk;
    logic [DATA_W-1:0] data;
  } ack_exp_t;

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_exp_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              p0_enable_i = 1'b0, p0_write_i = 1'b0;
  logic [ADDR_W-1:0] p0_addr_i = '0;
  logic [DATA_W-1:0] p0_data_i = '0;
  logic [DATA_W-1:0] p0_data_o;
  logic              p0_ack_o;
  logic              p1_enable_i = 1'b0, p1_write_i = 1'b0;
  logic [ADDR_W-1:0] p1_addr_i = '0;
  logic [DATA_W-1:0] p1_data_i = '0;
  logic [DATA_W-1:0] p1_data_o;
  logic              p1_ack_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic              err_o, busy_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_delay = 0;
  int inj_cnt = 0;
  ack_exp_t ack_q[$];
  mem_exp_t mem_q[$];
  int grant_cyc_q[$];
  int mem_ack_cyc_q[$];

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = a ^ (32'h1357_9BDF + 32'(i) * 32'h0101_0101);
    return l;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ack(input logic port, input logic chk, input logic [DATA_W-1:0] d);
    ack_q.push_back('{port: port, chk: chk, data: d});
  endtask

  task automatic push_mem(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mem_q.push_back('{write: w, addr: a, data: d});
  endtask

  task automatic start_req(input logic port, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    if (port) begin
      p1_write_i = w; p1_addr_i = a; p1_data_i = d; p1_enable_i = 1'b1;
    end else begin
      p0_write_i = w; p0_addr_i = a; p0_data_i = d; p0_enable_i = 1'b1;
    end
  endtask

  // Waits (bounded) for this port's ack and drops enable in the ack cycle.
  task automatic wait_ack(input logic port, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk_i); #1;
      seen = port ? p1_ack_o : p0_ack_o;
    end
    if (port) p1_enable_i = 1'b0; else p0_enable_i = 1'b0;
    check(port ? "p1_ack_seen" : "p0_ack_seen", DATA_W'(seen), DATA_W'(1'b1));
  endtask

  task automatic port_txn(input logic port, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    start_req(port, w, a, d);
    wait_ack(port, 300);
  endtask

  task automatic do_reset();
    rst_i = 1'b0; p0_enable_i = 1'b0; p1_enable_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // Memory model: checks each grant against the expected queue, acks after ack_delay cycles.
  initial begin : mem_model
    int cnt;
    int inj_seen;
    mem_exp_t cur;
    cnt = 0; inj_seen = 0;
    cur = '{write: 1'b0, addr: '0, data: '0};
    mem_ack_i = 1'b0; mem_data_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      if (mem_enable_o) begin
        cnt++;
        if (cnt == 1) begin
          grant_cyc_q.push_back(cyc);
          check("grant_expected", DATA_W'(mem_q.size() != 0), DATA_W'(1'b1));
          if (mem_q.size() != 0) begin
            cur = mem_q.pop_front();
            check("grant_write", DATA_W'(mem_write_o), DATA_W'(cur.write));
            check("grant_addr", DATA_W'(mem_addr_o), DATA_W'(cur.addr));
            if (cur.write) check("grant_wdata", mem_data_o, cur.data);
          end
        end
      end else begin
        cnt = 0;
      end
      if (inj_cnt != inj_seen) begin
        inj_seen = inj_cnt;
        mem_ack_i = 1'b1;
        mem_data_i = mem_enable_o ? line_of(mem_addr_o) : {8{32'hBAD0_BAD0}};
        mem_ack_cyc_q.push_back(cyc);
      end else if (mem_enable_o && ack_delay > 0 && cnt == ack_delay) begin
        check("held_addr", DATA_W'(mem_addr_o), DATA_W'(cur.addr));
        mem_ack_i = 1'b1;
        mem_data_i = line_of(mem_addr_o);
        mem_ack_cyc_q.push_back(cyc);
      end
    end
  end

  // Ack monitor: every pN_ack_o must match the next expected completion.
  initial begin : monitor
    ack_exp_t e;
    logic port_s;
    forever begin
      @(posedge clk_i); #1;
      if (p0_ack_o || p1_ack_o) begin
        check("single_ack", DATA_W'(p0_ack_o & p1_ack_o), DATA_W'(1'b0));
        port_s = p1_ack_o;
        check("ack_expected", DATA_W'(ack_q.size() != 0), DATA_W'(1'b1));
        if (ack_q.size() != 0) begin
          e = ack_q.pop_front();
          check("ack_port", DATA_W'(port_s), DATA_W'(e.port));
          if (mem_ack_cyc_q.size() != 0)
            check("ack_latency", DATA_W'(cyc), DATA_W'(mem_ack_cyc_q[$] + 1));
          if (e.chk) check("ack_data", port_s ? p1_data_o : p0_data_o, e.data);
        end
      end
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int gbase, abase;
    logic [DATA_W-1:0] a5, d1, d2, d6;
    a5 = {32{8'hA5}};
    d1 = {8{32'h1111_2222}};
    d2 = {8{32'h3333_4444}};
    d6 = {8{32'hCAFE_F00D}};

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_mem_enable", DATA_W'(mem_enable_o), DATA_W'(1'b0));
    check("rst_mem_write", DATA_W'(mem_write_o), DATA_W'(1'b0));
    check("rst_mem_addr", DATA_W'(mem_addr_o), DATA_W'(1'b0));
    check("rst_mem_data", mem_data_o, '0);
    check("rst_acks", DATA_W'({p0_ack_o, p1_ack_o}), DATA_W'(2'b00));
    check("rst_p0_data", p0_data_o, '0);
    check("rst_p1_data", p1_data_o, '0);
    check("rst_err", DATA_W'(err_o), DATA_W'(1'b0));
    check("rst_busy", DATA_W'(busy_o), DATA_W'(1'b0));
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Port 0 alone reads 0x400.
    ack_delay = 10;
    push_mem(1'b0, 32'h0000_0400, '0);
    push_ack(1'b0, 1'b1, line_of(32'h0000_0400));
    start_req(1'b0, 1'b0, 32'h0000_0400, '0);
    check("t1_pre_enable", DATA_W'(mem_enable_o), DATA_W'(1'b0));
    @(posedge clk_i); #1;
    check("t1_enable", DATA_W'(mem_enable_o), DATA_W'(1'b1));
    check("t1_write", DATA_W'(mem_write_o), DATA_W'(1'b0));
    check("t1_addr", DATA_W'(mem_addr_o), DATA_W'(32'h0000_0400));
    check("t1_busy", DATA_W'(busy_o), DATA_W'(1'b1));
    wait_ack(1'b0, 40);
    @(posedge clk_i); #1;
    check("t1_idle_enable", DATA_W'(mem_enable_o), DATA_W'(1'b0));
    check("t1_p1_data", p1_data_o, '0);

    // Simultaneous requests straight after reset: port 0 first, then port 1 write.
    do_reset();
    ack_delay = 3;
    push_mem(1'b0, 32'h0000_0100, '0);
    push_mem(1'b1, 32'h0000_0200, a5);
    push_ack(1'b0, 1'b1, line_of(32'h0000_0100));
    push_ack(1'b1, 1'b0, '0);
    gbase = grant_cyc_q.size();
    abase = mem_ack_cyc_q.size();
    fork
      port_txn(1'b0, 1'b0, 32'h0000_0100, '0);
      port_txn(1'b1, 1'b1, 32'h0000_0200, a5);
    join
    if (grant_cyc_q.size() >= gbase + 2 && mem_ack_cyc_q.size() >= abase + 1)
      check("t2_turnaround", DATA_W'(grant_cyc_q[gbase+1]), DATA_W'(mem_ack_cyc_q[abase] + 3));
    else
      check("t2_turnaround_seen", DATA_W'(1'b0), DATA_W'(1'b1));
    check("t2_p1_data_unchanged", p1_data_o, '0);

    // Both held for four transactions: 0,1,0,1.
    do_reset();
    ack_delay = 2;
    push_mem(1'b0, 32'h0000_1000, '0);
    push_mem(1'b1, 32'h0000_2000, d1);
    push_mem(1'b1, 32'h0000_1040, d2);
    push_mem(1'b0, 32'h0000_2040, '0);
    push_ack(1'b0, 1'b1, line_of(32'h0000_1000));
    push_ack(1'b1, 1'b0, '0);
    push_ack(1'b0, 1'b0, '0);
    push_ack(1'b1, 1'b1, line_of(32'h0000_2040));
    fork
      begin
        port_txn(1'b0, 1'b0, 32'h0000_1000, '0);
        port_txn(1'b0, 1'b1, 32'h0000_1040, d2);
      end
      begin
        port_txn(1'b1, 1'b1, 32'h0000_2000, d1);
        port_txn(1'b1, 1'b0, 32'h0000_2040, '0);
      end
    join
    check("t3_p0_data_kept", p0_data_o, line_of(32'h0000_1000));

    // Mid-grant input change, then a spurious ack while idle.
    do_reset();
    ack_delay = 8;
    push_mem(1'b0, 32'h0000_0300, '0);
    push_ack(1'b0, 1'b1, line_of(32'h0000_0300));
    start_req(1'b0, 1'b0, 32'h0000_0300, '0);
    repeat (3) begin @(posedge clk_i); #1; end
    p0_addr_i = 32'h0000_7FC0; p0_write_i = 1'b1; p0_data_i = '1;
    @(posedge clk_i); #1;
    check("t4_addr_latched", DATA_W'(mem_addr_o), DATA_W'(32'h0000_0300));
    check("t4_write_latched", DATA_W'(mem_write_o), DATA_W'(1'b0));
    wait_ack(1'b0, 40);
    repeat (2) begin @(posedge clk_i); #1; end
    inj_cnt++;
    repeat (3) begin @(posedge clk_i); #1; end
    check("t4_spur_busy", DATA_W'(busy_o), DATA_W'(1'b0));
    check("t4_spur_enable", DATA_W'(mem_enable_o), DATA_W'(1'b0));
    check("t4_spur_p0_data", p0_data_o, line_of(32'h0000_0300));
    check("t4_spur_p1_data", p1_data_o, '0);
    push_mem(1'b0, 32'h0000_0080, '0);
    push_ack(1'b1, 1'b1, line_of(32'h0000_0080));
    port_txn(1'b1, 1'b0, 32'h0000_0080, '0);

    // Memory never acks: watchdog at TIMEOUT, late ack still completes.
    do_reset();
    ack_delay = 0;
    push_mem(1'b0, 32'h0000_0500, '0);
    push_ack(1'b0, 1'b1, line_of(32'h0000_0500));
    start_req(1'b0, 1'b0, 32'h0000_0500, '0);
    @(posedge clk_i); #1;
    check("t5_granted", DATA_W'(mem_enable_o), DATA_W'(1'b1));
    repeat (TIMEOUT - 1) begin @(posedge clk_i); #1; end
    check("t5_err_before", DATA_W'(err_o), DATA_W'(1'b0));
    @(posedge clk_i); #1;
    check("t5_err_at_timeout", DATA_W'(err_o), DATA_W'(1'b1));
    check("t5_enable_held", DATA_W'(mem_enable_o), DATA_W'(1'b1));
    repeat (15) begin @(posedge clk_i); #1; end
    inj_cnt++;
    wait_ack(1'b0, 10);
    repeat (4) begin @(posedge clk_i); #1; end
    check("t5_err_sticky", DATA_W'(err_o), DATA_W'(1'b1));
    check("t5_idle_after_late", DATA_W'(busy_o), DATA_W'(1'b0));

    // Asynchronous reset mid-GNT1, then a tie goes to port 0.
    do_reset();
    check("t6_err_cleared", DATA_W'(err_o), DATA_W'(1'b0));
    ack_delay = 0;
    push_mem(1'b1, 32'h0000_0600, d6);
    start_req(1'b1, 1'b1, 32'h0000_0600, d6);
    @(posedge clk_i); #1;
    check("t6_gnt1_enable", DATA_W'(mem_enable_o), DATA_W'(1'b1));
    repeat (3) begin @(posedge clk_i); #1; end
    #3 rst_i = 1'b0;
    p1_enable_i = 1'b0;
    #1;
    check("t6_rst_enable", DATA_W'(mem_enable_o), DATA_W'(1'b0));
    check("t6_rst_busy", DATA_W'(busy_o), DATA_W'(1'b0));
    check("t6_rst_write", DATA_W'(mem_write_o), DATA_W'(1'b0));
    check("t6_rst_addr", DATA_W'(mem_addr_o), DATA_W'(1'b0));
    check("t6_rst_data", mem_data_o, '0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    ack_delay = 4;
    push_mem(1'b0, 32'h0000_0700, '0);
    push_mem(1'b0, 32'h0000_0780, '0);
    push_ack(1'b0, 1'b1, line_of(32'h0000_0700));
    push_ack(1'b1, 1'b1, line_of(32'h0000_0780));
    fork
      port_txn(1'b0, 1'b0, 32'h0000_0700, '0);
      port_txn(1'b1, 1'b0, 32'h0000_0780, '0);
    join

    repeat (5) @(posedge clk_i);
    #1;
    check("end_ack_queue_empty", DATA_W'(ack_q.size()), DATA_W'(0));
    check("end_mem_queue_empty", DATA_W'(mem_q.size()), DATA_W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
